// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush sequencer.
// Holds the Tuse/Tnew encodings, the default multiply/divide busy lengths,
// the register-zero constant and the per-source data-hazard compare.
package hazard_stall_ctrl_pkg;

  localparam logic [1:0] TUSE_NONE    = 2'd3;  // source operand not read
  localparam logic [4:0] REG_ZERO     = 5'd0;  // $0: never a real dependency
  localparam int         MULT_CYC_DEF = 5;
  localparam int         DIV_CYC_DEF  = 10;
  localparam int         CNT_W_DEF    = 4;

  // True when source register ra is still being produced by E or M and the
  // result arrives later than D needs it (Tnew > Tuse, unsigned 2-bit).
  function automatic logic src_hazard(
    input logic [4:0] ra,
    input logic [1:0] tuse,
    input logic [4:0] e_wa,
    input logic [1:0] e_tnew,
    input logic [4:0] m_wa,
    input logic [1:0] m_tnew
  );
    return (ra != REG_ZERO) && (tuse != TUSE_NONE) &&
           (((e_wa == ra) && (e_tnew > tuse)) ||
            ((m_wa == ra) && (m_tnew > tuse)));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_cnt.sv
// Busy counter for the iterative HI/LO multiply/divide unit.
// Ports: clk/reset (sync, active-high); start_i/div_i = mult/div issue in E;
//        busy_o = unit busy this cycle (issue cycle or count still running).
module hazard_stall_ctrl_md_busy_cnt
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic div_i,
  output logic busy_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A new issue always reloads, even if a previous op is still counting;
  // that overlap is normally prevented upstream by the md stall.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i)
      cnt_d = div_i ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    else if (cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Busy covers the issue cycle itself plus the N cycles the count runs.
  assign busy_o = start_i | (cnt_q != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline (F/D/E/M/W).
// Ports: D_* = instr in decode (sources, Tuse, md use); E_*/M_* = producers
//        (dest, Tnew) and md issue; outputs stall, D_we, pc_we, E_clr,
//        md_busy and a saturating stalled-cycle counter stall_cnt.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_tuse_rs,
  input  logic [1:0]  D_tuse_rt,
  input  logic        D_md_use,
  input  logic [4:0]  E_wa,
  input  logic [1:0]  E_tnew,
  input  logic [4:0]  M_wa,
  input  logic [1:0]  M_tnew,
  input  logic        E_md_start,
  input  logic        E_md_div,
  output logic        stall,
  output logic        D_we,
  output logic        pc_we,
  output logic        E_clr,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  logic        stall_rs, stall_rt, stall_md;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  hazard_stall_ctrl_md_busy_cnt #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_md_busy_cnt (
    .clk     (clk),
    .reset   (reset),
    .start_i (E_md_start),
    .div_i   (E_md_div),
    .busy_o  (md_busy)
  );

  assign stall_rs = src_hazard(D_rs, D_tuse_rs, E_wa, E_tnew, M_wa, M_tnew);
  assign stall_rt = src_hazard(D_rt, D_tuse_rt, E_wa, E_tnew, M_wa, M_tnew);
  assign stall_md = D_md_use & md_busy;

  // Same-cycle decision: freeze F/D and PC, squash the instr entering E.
  assign stall = stall_rs | stall_rt | stall_md;
  assign D_we  = ~stall;
  assign pc_we = ~stall;
  assign E_clr = stall;

  // One count per stalled cycle regardless of how many causes overlap;
  // holds at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= 32'd0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;
  import hazard_stall_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rs, D_rt, E_wa, M_wa;
  logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
  logic        D_md_use, E_md_start, E_md_div;
  logic        stall, D_we, pc_we, E_clr, md_busy;
  logic [31:0] stall_cnt;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_cnt;

  hazard_stall_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .D_rs       (D_rs),
    .D_rt       (D_rt),
    .D_tuse_rs  (D_tuse_rs),
    .D_tuse_rt  (D_tuse_rt),
    .D_md_use   (D_md_use),
    .E_wa       (E_wa),
    .E_tnew     (E_tnew),
    .M_wa       (M_wa),
    .M_tnew     (M_tnew),
    .E_md_start (E_md_start),
    .E_md_div   (E_md_div),
    .stall      (stall),
    .D_we       (D_we),
    .pc_we      (pc_we),
    .E_clr      (E_clr),
    .md_busy    (md_busy),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt;
    logic [1:0] tuse_rs, tuse_rt;
    logic       md_use;
    logic [4:0] e_wa;
    logic [1:0] e_tnew;
    logic [4:0] m_wa;
    logic [1:0] m_tnew;
    logic       exp_stall;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    D_rs = 5'd0; D_rt = 5'd0; D_tuse_rs = TUSE_NONE; D_tuse_rt = TUSE_NONE;
    D_md_use = 1'b0; E_wa = 5'd0; E_tnew = 2'd0; M_wa = 5'd0; M_tnew = 2'd0;
    E_md_start = 1'b0; E_md_div = 1'b0;
  endtask

  // Check the four stall-derived outputs against one expected stall value.
  task automatic check_stall(input string name, input logic exp_s);
    check({name, ".stall"}, {31'd0, stall}, {31'd0, exp_s});
    check({name, ".D_we"},  {31'd0, D_we},  {31'd0, ~exp_s});
    check({name, ".pc_we"}, {31'd0, pc_we}, {31'd0, ~exp_s});
    check({name, ".E_clr"}, {31'd0, E_clr}, {31'd0, exp_s});
  endtask

  // Advance one edge and track the expected saturating counter.
  task automatic tick(input logic stalled);
    @(posedge clk);
    if (reset) exp_cnt = 32'd0;
    else if (stalled && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
  endtask

  initial begin
    //                rs  rt  tRs tRt md  Ewa Etn Mwa Mtn exp
    vecs[0]  = '{5'd1, 5'd0, 2'd1, 2'd3, 1'b0, 5'd1, 2'd2, 5'd0, 2'd0, 1'b1}; // lw->add
    vecs[1]  = '{5'd1, 5'd0, 2'd1, 2'd3, 1'b0, 5'd0, 2'd2, 5'd0, 2'd0, 1'b0}; // E_wa=0
    vecs[2]  = '{5'd0, 5'd0, 2'd1, 2'd3, 1'b0, 5'd0, 2'd2, 5'd0, 2'd0, 1'b0}; // $0 src
    vecs[3]  = '{5'd0, 5'd5, 2'd3, 2'd0, 1'b0, 5'd0, 2'd0, 5'd5, 2'd1, 1'b1}; // M hazard rt
    vecs[4]  = '{5'd0, 5'd5, 2'd3, 2'd1, 1'b0, 5'd0, 2'd0, 5'd5, 2'd1, 1'b0}; // tnew==tuse
    vecs[5]  = '{5'd1, 5'd0, 2'd3, 2'd3, 1'b0, 5'd1, 2'd3, 5'd0, 2'd0, 1'b0}; // tuse none
    vecs[6]  = '{5'd7, 5'd0, 2'd1, 2'd3, 1'b0, 5'd7, 2'd1, 5'd0, 2'd0, 1'b0}; // E equal
    vecs[7]  = '{5'd3, 5'd4, 2'd0, 2'd0, 1'b0, 5'd3, 2'd1, 5'd4, 2'd2, 1'b1}; // both srcs
    vecs[8]  = '{5'd4, 5'd0, 2'd0, 2'd3, 1'b0, 5'd3, 2'd2, 5'd0, 2'd0, 1'b0}; // addr miss
    vecs[9]  = '{5'd0, 5'd9, 2'd3, 2'd0, 1'b0, 5'd9, 2'd1, 5'd0, 2'd0, 1'b1}; // E hazard rt
    vecs[10] = '{5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0}; // md idle
    vecs[11] = '{5'd2, 5'd0, 2'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd2, 2'd1, 1'b1}; // M hazard rs

    idle_inputs();
    reset = 1'b1;
    exp_cnt = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("rst.stall_cnt", stall_cnt, 32'd0);
    check("rst.md_busy", {31'd0, md_busy}, 32'd0);
    check_stall("rst", 1'b0);

    // Table of single-cycle data-hazard vectors.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      idle_inputs();
      D_rs = vecs[i].rs; D_rt = vecs[i].rt;
      D_tuse_rs = vecs[i].tuse_rs; D_tuse_rt = vecs[i].tuse_rt;
      D_md_use = vecs[i].md_use;
      E_wa = vecs[i].e_wa; E_tnew = vecs[i].e_tnew;
      M_wa = vecs[i].m_wa; M_tnew = vecs[i].m_tnew;
      #2;
      check_stall($sformatf("vec%0d", i), vecs[i].exp_stall);
      check($sformatf("vec%0d.md_busy", i), {31'd0, md_busy}, 32'd0);
      tick(vecs[i].exp_stall);
      #1;
      check($sformatf("vec%0d.stall_cnt", i), stall_cnt, exp_cnt);
    end

    // Multiply followed by mflo: 6 stalled cycles, then proceeds.
    // Cycle 1 also carries a data hazard to confirm a single count.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle_inputs();
      D_md_use = 1'b1;
      E_md_start = (i == 0);
      if (i == 1) begin
        D_rs = 5'd1; D_tuse_rs = 2'd0; E_wa = 5'd1; E_tnew = 2'd1;
      end
      #2;
      check_stall($sformatf("mult%0d", i), i < 6);
      check($sformatf("mult%0d.md_busy", i), {31'd0, md_busy}, {31'd0, i < 6});
      tick(i < 6);
    end
    #1;
    check("mult.stall_cnt", stall_cnt, exp_cnt);

    // Divide: busy for 11 cycles; no md user in D so no stall.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      idle_inputs();
      E_md_start = (i == 0);
      E_md_div = 1'b1;
      #2;
      check($sformatf("div%0d.md_busy", i), {31'd0, md_busy}, {31'd0, i < 11});
      check($sformatf("div%0d.stall", i), {31'd0, stall}, 32'd0);
      tick(1'b0);
    end

    // Divide interrupted by reset when the count has reached 4.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle_inputs();
      D_md_use = 1'b1;
      E_md_start = (i == 0);
      E_md_div = 1'b1;
      reset = (i == 7);
      #2;
      check($sformatf("divrst%0d.md_busy", i), {31'd0, md_busy}, 32'd1);
      tick(1'b1);
    end
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("divrst.after.md_busy", {31'd0, md_busy}, 32'd0);
    check_stall("divrst.after", 1'b0);
    check("divrst.after.stall_cnt", stall_cnt, 32'd0);
    exp_cnt = 32'd0;

    // Saturation: preload near all-ones, keep stalling.
    @(negedge clk);
    idle_inputs();
    D_rs = 5'd1; D_tuse_rs = 2'd1; E_wa = 5'd1; E_tnew = 2'd2;
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    exp_cnt = 32'hFFFF_FFFD;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1);
      #1;
      check($sformatf("sat%0d.stall_cnt", i), stall_cnt, exp_cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
